ysyx_23060077_mem_arbiter: RTL and testbench
============================================

# ysyx_23060077_mem_arbiter

Shares the core's single memory master port between the instruction-fetch read requester (IFU) and the load/store unit (LSU read and LSU write). Sits between the pipeline units and the AXI bridge and speaks the same simplified valid/ready/last request protocol the IFU already drives. It grants one transaction at a time with a registered four-state FSM and steers response data back only to the granted requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 8, burst length field width (beats − 1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ifu_r_valid_i  in  1  IFU read request, held until completion
- ifu_r_addr_i  in  ADDR_W  IFU read address
- ifu_r_len_i  in  LEN_W  IFU burst length
- ifu_r_ready_o  out  1  IFU beat valid
- ifu_r_data_o  out  DATA_W  IFU beat data
- ifu_r_last_o  out  1  IFU final beat
- lsu_r_valid_i / lsu_r_addr_i / lsu_r_len_i  in  1/ADDR_W/LEN_W  LSU read request
- lsu_r_ready_o / lsu_r_data_o / lsu_r_last_o  out  1/DATA_W/1  LSU read response
- lsu_w_valid_i  in  1  LSU write request, held until completion
- lsu_w_addr_i  in  ADDR_W  write address
- lsu_w_data_i  in  DATA_W  write data
- lsu_w_strb_i  in  DATA_W/8  byte strobes
- lsu_w_ready_o  out  1  write accepted (completion)
- m_r_valid_o / m_r_addr_o / m_r_len_o  out  1/ADDR_W/LEN_W  downstream read request
- m_r_ready_i / m_r_data_i / m_r_last_i  in  1/DATA_W/1  downstream read response
- m_w_valid_o / m_w_addr_o / m_w_data_o / m_w_strb_o  out  downstream write request
- m_w_ready_i  in  1  downstream write completion
- arb_busy_o  out  1  FSM not in IDLE

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR; one-hot or encoded, registered.
- IDLE: pick winner among asserted requests; next state = winner's state. No requests → stay IDLE.
- Within LSU: lsu_w_valid_i beats lsu_r_valid_i.
- Fixed priority (default): LSU_WR > LSU_RD > IFU_RD.
- IFU_RD / LSU_RD: m_r_valid_o=1; m_r_addr_o/m_r_len_o muxed from granted requester; m_r_ready_i/m_r_data_i/m_r_last_i routed to granted requester only. Exit to IDLE when m_r_ready_i & m_r_last_i.
- LSU_WR: m_w_valid_o=1 with LSU write fields; lsu_w_ready_o = m_w_ready_i. Exit to IDLE when m_w_ready_i.
- Non-granted requesters see ready=0, last=0, data=0.
- Requester dropping valid mid-grant: grant held until downstream completion; response still routed (protocol violation, no error).
- Downstream response outside a read state ignored; all requester readies stay 0.

## Timing
- Reset: state IDLE, all *_valid_o, *_ready_o, *_last_o, arb_busy_o = 0; data/addr outputs 0; rr pointer = "LSU served last".
- Request sampled in IDLE at cycle N → m_*_valid_o high at N+1 (one-cycle grant latency).
- Response path purely combinational, zero added latency per beat.
- Completion cycle C → IDLE at C+1 → next grant earliest C+2 downstream valid (one bubble). Requester must deassert valid in C+1 (IFU does).
- Simultaneous requests in IDLE: resolved by priority/rr in one cycle; losers keep valid asserted and wait.
- Reset asserted mid-transaction: FSM to IDLE next edge, in-flight response discarded; downstream must be reset together.
- Burst beats counted by last only; no internal beat counter, len passed through unchanged.

## Configuration
- YSYX_23060077_ARB_RR_EN defined: round-robin between IFU and LSU (LSU write still beats LSU read). 1-bit pointer updated at each grant; on contention the class not served last wins. Reset pointer grants IFU first.
- Undefined: fixed priority as in Operation; no pointer register.

## Test plan
- IFU-only read addr 0x2000_0000 len 0, data 0x00000413 with last at cycle 3 → m_r_valid_o high cycles 1–3, ifu_r_ready_o/last 1 at cycle 3 with data 0x00000413, arb_busy_o 0 at cycle 4.
- IFU and LSU read (0x8000_0010) same cycle, fixed priority → LSU granted first, IFU granted two cycles after LSU last; IFU never sees ready during LSU grant.
- Same stimulus with YSYX_23060077_ARB_RR_EN after reset → IFU first, then LSU; repeat contention → alternates.
- LSU write 0x8000_0100 data 0xDEADBEEF strb 0xF concurrent with LSU read → write issued first, lsu_w_ready_o pulses with m_w_ready_i, read follows.
- 4-beat IFU burst (len 3) → exactly 4 routed beats, exit only on last.
- Reset at beat 2 of IFU burst → all outputs 0 next cycle, state IDLE, subsequent LSU read granted normally.

Source files
------------

// File: rtl/ysyx_23060077_mem_arbiter.sv
// Shares the single memory master port between IFU reads and LSU reads/writes.
// Define YSYX_23060077_ARB_RR_EN for round-robin between IFU and LSU.
module ysyx_23060077_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_r_valid_i,
  input  logic [ADDR_W-1:0]   ifu_r_addr_i,
  input  logic [LEN_W-1:0]    ifu_r_len_i,
  output logic                ifu_r_ready_o,
  output logic [DATA_W-1:0]   ifu_r_data_o,
  output logic                ifu_r_last_o,
  input  logic                lsu_r_valid_i,
  input  logic [ADDR_W-1:0]   lsu_r_addr_i,
  input  logic [LEN_W-1:0]    lsu_r_len_i,
  output logic                lsu_r_ready_o,
  output logic [DATA_W-1:0]   lsu_r_data_o,
  output logic                lsu_r_last_o,
  input  logic                lsu_w_valid_i,
  input  logic [ADDR_W-1:0]   lsu_w_addr_i,
  input  logic [DATA_W-1:0]   lsu_w_data_i,
  input  logic [DATA_W/8-1:0] lsu_w_strb_i,
  output logic                lsu_w_ready_o,
  output logic                m_r_valid_o,
  output logic [ADDR_W-1:0]   m_r_addr_o,
  output logic [LEN_W-1:0]    m_r_len_o,
  input  logic                m_r_ready_i,
  input  logic [DATA_W-1:0]   m_r_data_i,
  input  logic                m_r_last_i,
  output logic                m_w_valid_o,
  output logic [ADDR_W-1:0]   m_w_addr_o,
  output logic [DATA_W-1:0]   m_w_data_o,
  output logic [DATA_W/8-1:0] m_w_strb_o,
  input  logic                m_w_ready_i,
  output logic                arb_busy_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IFU_RD = 2'd1;
  localparam logic [1:0] LSU_RD = 2'd2;
  localparam logic [1:0] LSU_WR = 2'd3;

  logic [1:0] state;
  logic [1:0] state_n;
  logic       lsu_any;
  logic       ifu_win;

  assign lsu_any = lsu_r_valid_i | lsu_w_valid_i;

`ifdef YSYX_23060077_ARB_RR_EN
  // Set when the LSU class took the most recent grant.
  logic lsu_last;

  assign ifu_win = ifu_r_valid_i & (~lsu_any | lsu_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_last <= 1'b1;
    end else if (state == IDLE && state_n != IDLE) begin
      lsu_last <= (state_n != IFU_RD);
    end
  end
`else
  assign ifu_win = ifu_r_valid_i & ~lsu_any;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (lsu_w_valid_i && !ifu_win) begin
          state_n = LSU_WR;
        end else if (lsu_r_valid_i && !ifu_win) begin
          state_n = LSU_RD;
        end else if (ifu_r_valid_i) begin
          state_n = IFU_RD;
        end
      end
      IFU_RD, LSU_RD: begin
        if (m_r_ready_i && m_r_last_i) begin
          state_n = IDLE;
        end
      end
      LSU_WR: begin
        if (m_w_ready_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  logic g_ifu;
  logic g_lsr;
  logic g_lsw;

  assign g_ifu = (state == IFU_RD);
  assign g_lsr = (state == LSU_RD);
  assign g_lsw = (state == LSU_WR);

  assign arb_busy_o  = (state != IDLE);
  assign m_r_valid_o = g_ifu | g_lsr;
  assign m_r_addr_o  = g_ifu ? ifu_r_addr_i :
                       g_lsr ? lsu_r_addr_i : '0;
  assign m_r_len_o   = g_ifu ? ifu_r_len_i :
                       g_lsr ? lsu_r_len_i : '0;

  // Responses reach only the granted requester.
  assign ifu_r_ready_o = g_ifu & m_r_ready_i;
  assign ifu_r_last_o  = g_ifu & m_r_last_i;
  assign ifu_r_data_o  = g_ifu ? m_r_data_i : '0;
  assign lsu_r_ready_o = g_lsr & m_r_ready_i;
  assign lsu_r_last_o  = g_lsr & m_r_last_i;
  assign lsu_r_data_o  = g_lsr ? m_r_data_i : '0;

  assign m_w_valid_o   = g_lsw;
  assign m_w_addr_o    = g_lsw ? lsu_w_addr_i : '0;
  assign m_w_data_o    = g_lsw ? lsu_w_data_i : '0;
  assign m_w_strb_o    = g_lsw ? lsu_w_strb_i : '0;
  assign lsu_w_ready_o = g_lsw & m_w_ready_i;

endmodule

// File: tb/tb_ysyx_23060077_mem_arbiter.sv
// Bench for ysyx_23060077_mem_arbiter: directed table, hand sequences,
// and random stimulus against a transaction-level ownership model.
module tb_ysyx_23060077_mem_arbiter;

  localparam logic [31:0] IA    = 32'h2000_0000;
  localparam logic [31:0] LA    = 32'h8000_0010;
  localparam logic [31:0] WA    = 32'h8000_0100;
  localparam logic [31:0] WD    = 32'hDEAD_BEEF;
  localparam logic [31:0] MDATA = 32'h0000_0413;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_r_valid_i = 1'b0;
  logic [31:0] ifu_r_addr_i = '0;
  logic [7:0]  ifu_r_len_i = '0;
  logic        ifu_r_ready_o;
  logic [31:0] ifu_r_data_o;
  logic        ifu_r_last_o;
  logic        lsu_r_valid_i = 1'b0;
  logic [31:0] lsu_r_addr_i = '0;
  logic [7:0]  lsu_r_len_i = '0;
  logic        lsu_r_ready_o;
  logic [31:0] lsu_r_data_o;
  logic        lsu_r_last_o;
  logic        lsu_w_valid_i = 1'b0;
  logic [31:0] lsu_w_addr_i = '0;
  logic [31:0] lsu_w_data_i = '0;
  logic [3:0]  lsu_w_strb_i = '0;
  logic        lsu_w_ready_o;
  logic        m_r_valid_o;
  logic [31:0] m_r_addr_o;
  logic [7:0]  m_r_len_o;
  logic        m_r_ready_i = 1'b0;
  logic [31:0] m_r_data_i = '0;
  logic        m_r_last_i = 1'b0;
  logic        m_w_valid_o;
  logic [31:0] m_w_addr_o;
  logic [31:0] m_w_data_o;
  logic [3:0]  m_w_strb_o;
  logic        m_w_ready_i = 1'b0;
  logic        arb_busy_o;

  ysyx_23060077_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i),
    .ifu_r_len_i(ifu_r_len_i), .ifu_r_ready_o(ifu_r_ready_o),
    .ifu_r_data_o(ifu_r_data_o), .ifu_r_last_o(ifu_r_last_o),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
    .lsu_r_len_i(lsu_r_len_i), .lsu_r_ready_o(lsu_r_ready_o),
    .lsu_r_data_o(lsu_r_data_o), .lsu_r_last_o(lsu_r_last_o),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i),
    .lsu_w_data_i(lsu_w_data_i), .lsu_w_strb_i(lsu_w_strb_i),
    .lsu_w_ready_o(lsu_w_ready_o),
    .m_r_valid_o(m_r_valid_o), .m_r_addr_o(m_r_addr_o),
    .m_r_len_o(m_r_len_o), .m_r_ready_i(m_r_ready_i),
    .m_r_data_i(m_r_data_i), .m_r_last_i(m_r_last_i),
    .m_w_valid_o(m_w_valid_o), .m_w_addr_o(m_w_addr_o),
    .m_w_data_o(m_w_data_o), .m_w_strb_o(m_w_strb_o),
    .m_w_ready_i(m_w_ready_i), .arb_busy_o(arb_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mrv;
    logic        mwv;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic        ird;
    logic        ilast;
    logic [31:0] idata;
    logic        lrd;
    logic        llast;
    logic [31:0] ldata;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wrd;
    logic        busy;
  } obs_t;

  // in: {rst,iv,rv,wv,mrdy,mlast,wrdy}
  // ex: {mrv,mwv,ifu_grant,ird,lsu_grant,lrd,wrd,busy}
  typedef struct packed {
    logic [6:0]  in;
    logic [7:0]  ex;
    logic [31:0] raddr;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who currently owns the master port.
  localparam int NONE = 0;
  localparam int IFU  = 1;
  localparam int LRD  = 2;
  localparam int LWR  = 3;
  int owner = NONE;
  bit take_lsu;
`ifdef YSYX_23060077_ARB_RR_EN
  bit lsu_served_last = 1'b1;
`endif

  always @(posedge clk) begin
    if (reset) begin
      owner = NONE;
`ifdef YSYX_23060077_ARB_RR_EN
      lsu_served_last = 1'b1;
`endif
    end else if (owner == NONE) begin
      if (ifu_r_valid_i || lsu_r_valid_i || lsu_w_valid_i) begin
        take_lsu = lsu_r_valid_i || lsu_w_valid_i;
`ifdef YSYX_23060077_ARB_RR_EN
        if (ifu_r_valid_i && lsu_served_last) take_lsu = 1'b0;
        lsu_served_last = take_lsu;
`endif
        owner = !take_lsu ? IFU : (lsu_w_valid_i ? LWR : LRD);
      end
    end else if (owner == LWR) begin
      if (m_w_ready_i) owner = NONE;
    end else if (m_r_ready_i && m_r_last_i) begin
      owner = NONE;
    end
  end

  function automatic obs_t model_exp();
    obs_t e;
    e = '0;
    e.busy = (owner != NONE);
    if (owner == IFU) begin
      e.mrv = 1'b1; e.raddr = ifu_r_addr_i; e.rlen = ifu_r_len_i;
      e.ird = m_r_ready_i; e.ilast = m_r_last_i; e.idata = m_r_data_i;
    end
    if (owner == LRD) begin
      e.mrv = 1'b1; e.raddr = lsu_r_addr_i; e.rlen = lsu_r_len_i;
      e.lrd = m_r_ready_i; e.llast = m_r_last_i; e.ldata = m_r_data_i;
    end
    if (owner == LWR) begin
      e.mwv = 1'b1; e.waddr = lsu_w_addr_i; e.wdata = lsu_w_data_i;
      e.wstrb = lsu_w_strb_i; e.wrd = m_w_ready_i;
    end
    return e;
  endfunction

  function automatic obs_t actual();
    obs_t a;
    a.mrv = m_r_valid_o;     a.mwv = m_w_valid_o;
    a.raddr = m_r_addr_o;    a.rlen = m_r_len_o;
    a.ird = ifu_r_ready_o;   a.ilast = ifu_r_last_o;
    a.idata = ifu_r_data_o;  a.lrd = lsu_r_ready_o;
    a.llast = lsu_r_last_o;  a.ldata = lsu_r_data_o;
    a.waddr = m_w_addr_o;    a.wdata = m_w_data_o;
    a.wstrb = m_w_strb_o;    a.wrd = lsu_w_ready_o;
    a.busy = arb_busy_o;
    return a;
  endfunction

  function automatic obs_t vec_exp(vec_t v);
    obs_t e;
    e = '0;
    e.mrv = v.ex[7];  e.mwv = v.ex[6];
    e.raddr = v.raddr;
    e.ird = v.ex[4];  e.ilast = v.ex[4];
    e.idata = v.ex[5] ? MDATA : 32'h0;
    e.lrd = v.ex[2];  e.llast = v.ex[2];
    e.ldata = v.ex[3] ? MDATA : 32'h0;
    e.waddr = v.ex[6] ? WA : 32'h0;
    e.wdata = v.ex[6] ? WD : 32'h0;
    e.wstrb = v.ex[6] ? 4'hF : 4'h0;
    e.wrd = v.ex[1];  e.busy = v.ex[0];
    return e;
  endfunction

  function automatic vec_t mk(logic [6:0] i, logic [7:0] x, logic [31:0] a);
    vec_t v;
    v.in = i; v.ex = x; v.raddr = a;
    return v;
  endfunction

  task automatic check(input obs_t e, input string name);
    obs_t a;
    a = actual();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    ifu_r_valid_i = 1'b0; lsu_r_valid_i = 1'b0; lsu_w_valid_i = 1'b0;
    m_r_ready_i = 1'b0;   m_r_last_i = 1'b0;    m_w_ready_i = 1'b0;
  endtask

  vec_t tbl[$];
  int offered;
  int routed;
  bit done;

  initial begin
    ifu_r_addr_i = IA; lsu_r_addr_i = LA;
    lsu_w_addr_i = WA; lsu_w_data_i = WD; lsu_w_strb_i = 4'hF;
    m_r_data_i = MDATA;
    @(negedge clk);
    @(negedge clk);

    // IFU-only single-beat read
    tbl.push_back(mk(7'b1000000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0100000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0100000, 8'b10100001, IA));
    tbl.push_back(mk(7'b0100000, 8'b10100001, IA));
    tbl.push_back(mk(7'b0100110, 8'b10110001, IA));
    tbl.push_back(mk(7'b0000000, 8'b00000000, 32'h0));
    // IFU and LSU read contend right after reset
    tbl.push_back(mk(7'b1110000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0110000, 8'b00000000, 32'h0));
`ifdef YSYX_23060077_ARB_RR_EN
    tbl.push_back(mk(7'b0110000, 8'b10100001, IA));
    tbl.push_back(mk(7'b0110110, 8'b10110001, IA));
    tbl.push_back(mk(7'b0010000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0010000, 8'b10001001, LA));
    tbl.push_back(mk(7'b0010110, 8'b10001101, LA));
    tbl.push_back(mk(7'b0000000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0110000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0110000, 8'b10100001, IA));
    tbl.push_back(mk(7'b0110110, 8'b10110001, IA));
    tbl.push_back(mk(7'b0010000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0010000, 8'b10001001, LA));
    tbl.push_back(mk(7'b0010110, 8'b10001101, LA));
`else
    tbl.push_back(mk(7'b0110000, 8'b10001001, LA));
    tbl.push_back(mk(7'b0110110, 8'b10001101, LA));
    tbl.push_back(mk(7'b0100000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0100000, 8'b10100001, IA));
    tbl.push_back(mk(7'b0100110, 8'b10110001, IA));
`endif
    tbl.push_back(mk(7'b0000000, 8'b00000000, 32'h0));
    // LSU write beats a concurrent LSU read
    tbl.push_back(mk(7'b0011000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0011000, 8'b01000001, 32'h0));
    tbl.push_back(mk(7'b0011001, 8'b01000011, 32'h0));
    tbl.push_back(mk(7'b0010000, 8'b00000000, 32'h0));
    tbl.push_back(mk(7'b0010000, 8'b10001001, LA));
    tbl.push_back(mk(7'b0010110, 8'b10001101, LA));
    tbl.push_back(mk(7'b0000000, 8'b00000000, 32'h0));

    foreach (tbl[k]) begin
      {reset, ifu_r_valid_i, lsu_r_valid_i, lsu_w_valid_i,
       m_r_ready_i, m_r_last_i, m_w_ready_i} = tbl[k].in;
      #1;
      check(vec_exp(tbl[k]), $sformatf("table[%0d]", k));
      @(negedge clk);
    end

    // 4-beat IFU burst with stalls: exactly 4 beats, exit only on last
    idle_inputs();
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h2000_0040; ifu_r_len_i = 8'd3;
    offered = 0; routed = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      m_r_ready_i = m_r_valid_o && c[0];
      m_r_last_i = m_r_ready_i && (offered == 3);
      #1;
      check(model_exp(), "burst");
      if (ifu_r_ready_o) routed++;
      if (m_r_ready_i) offered++;
      if (m_r_ready_i && m_r_last_i) done = 1'b1;
      @(negedge clk);
    end
    cmp("burst_done", 32'(done), 32'd1);
    cmp("burst_beats", routed, 32'd4);
    idle_inputs();
    #1;
    cmp("burst_idle", 32'(arb_busy_o), 32'd0);
    @(negedge clk);

    // Reset at beat 2 of an IFU burst
    ifu_r_valid_i = 1'b1;
    offered = 0;
    for (int c = 0; c < 10 && offered < 2; c++) begin
      m_r_ready_i = m_r_valid_o;
      #1;
      if (m_r_ready_i) offered++;
      @(negedge clk);
    end
    cmp("rst_beats", offered, 32'd2);
    reset = 1'b1; m_r_ready_i = 1'b1;
    @(negedge clk);
    reset = 1'b0; ifu_r_valid_i = 1'b0; lsu_r_valid_i = 1'b1;
    m_r_ready_i = 1'b1; m_r_last_i = 1'b1;
    #1;
    check(obs_t'('0), "after_reset");
    @(negedge clk);
    m_r_ready_i = 1'b0; m_r_last_i = 1'b0;
    #1;
    cmp("post_rst_valid", 32'(m_r_valid_o), 32'd1);
    cmp("post_rst_addr", m_r_addr_o, LA);
    @(negedge clk);
    m_r_ready_i = 1'b1; m_r_last_i = 1'b1;
    #1;
    cmp("post_rst_rdy", 32'(lsu_r_ready_o), 32'd1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    // Random traffic against the ownership model
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      ifu_r_valid_i = $urandom_range(0, 2) != 0;
      lsu_r_valid_i = $urandom_range(0, 2) == 0;
      lsu_w_valid_i = $urandom_range(0, 3) == 0;
      ifu_r_addr_i = $urandom; lsu_r_addr_i = $urandom;
      ifu_r_len_i = 8'($urandom); lsu_r_len_i = 8'($urandom);
      lsu_w_addr_i = $urandom; lsu_w_data_i = $urandom;
      lsu_w_strb_i = 4'($urandom);
      m_r_ready_i = $urandom_range(0, 1) != 0;
      m_r_last_i = $urandom_range(0, 2) == 0;
      m_r_data_i = $urandom;
      m_w_ready_i = $urandom_range(0, 2) == 0;
      #1;
      check(model_exp(), "random");
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
